board_row_fetcher: RTL and testbench

- Arbitrates the single data-RAM port between CPU load/store traffic and the VGA board renderer.
- Prefetches one 10-cell block row of the 10x20 game board (RAM words 0..199, colour in bits [2:0]) into a double-buffered line buffer.
- The renderer reads cell colours from the buffer rather than from RAM, so a CPU LW/SW no longer corrupts the displayed colour.
- Sits between the processor, data RAM and the VGA colour mux, in the CPU clock domain.

---
 rtl/board_row_fetcher_pkg.sv | 30 +++
 rtl/board_row_fetcher_if.sv | 23 ++
 rtl/board_row_fetcher_row_line_buffer.sv | 44 ++++
 rtl/board_row_fetcher.sv | 107 ++++++++++
 tb/tb_board_row_fetcher.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/board_row_fetcher_pkg.sv
// Shared constants and types for the board row prefetcher: board geometry,
// colour codes and the fetch state encoding.
package board_row_fetcher_pkg;

  localparam int unsigned COLS         = 10;
  localparam int unsigned ROWS         = 20;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam int unsigned ADDR_W       = 12;

  typedef logic [2:0] cell_t;

  typedef enum logic [2:0] {
    C_EMPTY  = 3'd0,
    C_CYAN   = 3'd1,
    C_YELLOW = 3'd2,
    C_GREEN  = 3'd3,
    C_RED    = 3'd4,
    C_PURPLE = 3'd5,
    C_ORANGE = 3'd6,
    C_BLUE   = 3'd7
  } colour_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/board_row_fetcher_if.sv
// CPU data-port and RAM-port signals shared by the fetcher and its
// CPU/RAM side; slave is the fetcher's view.
interface board_row_fetcher_if #(
  parameter int unsigned ADDR_W = board_row_fetcher_pkg::ADDR_W
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_wen;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [2:0]        mem_rdata;

  modport master (
    output cpu_req, cpu_addr, cpu_wen, mem_rdata,
    input  cpu_stall, mem_addr, mem_wen
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_wen, mem_rdata,
    output cpu_stall, mem_addr, mem_wen
  );
endinterface

// File: rtl/board_row_fetcher_row_line_buffer.sv
// Double-buffered row of cell colours: the fetcher fills the shadow copy
// while the renderer reads the active copy; swap copies shadow to active.
module row_line_buffer
  import board_row_fetcher_pkg::*;
#(
  parameter int unsigned COLS  = 10,
  parameter int unsigned IDX_W = $clog2(COLS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  cell_t            wr_data,
  input  logic             swap,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_idx,
  output cell_t            rd_data
);

  cell_t shadow [COLS];
  cell_t active [COLS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < COLS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (swap) active <= shadow;
      if (clear) begin
        for (int unsigned i = 0; i < COLS; i++) shadow[i] <= '0;
      end else if (wr_en) begin
        shadow[wr_idx] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < COLS) rd_data = active[rd_idx];
  end

endmodule

// File: rtl/board_row_fetcher.sv
// Shares the data-RAM port between CPU loads/stores and a one-row board
// prefetch into a line buffer that the VGA renderer reads from.
module board_row_fetcher
  import board_row_fetcher_pkg::*;
#(
  parameter int unsigned COLS         = board_row_fetcher_pkg::COLS,
  parameter int unsigned ROWS         = board_row_fetcher_pkg::ROWS,
  parameter int unsigned STARVE_LIMIT = board_row_fetcher_pkg::STARVE_LIMIT,
  parameter int unsigned ADDR_W       = board_row_fetcher_pkg::ADDR_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 row_start,
  input  logic [4:0]           row_idx,
  board_row_fetcher_if.slave   bus,
  input  logic [3:0]           col_idx,
  output cell_t                pix_color,
  output logic                 row_ready,
  output logic                 overrun
);

  localparam int unsigned K_W = $clog2(COLS);
  localparam int unsigned S_W = $clog2(STARVE_LIMIT + 1);

  fetch_state_t      state, state_nx;
  logic [ADDR_W-1:0] base;
  logic [K_W-1:0]    k, slot;
  logic [S_W-1:0]    starve;
  logic              issued;
  logic              fetch_go;
  logic              blank;

  assign blank     = 32'(row_idx) >= ROWS;
  assign row_ready = (state == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Arbitration and next state; the RAM port defaults to the CPU.
  always_comb begin
    fetch_go      = 1'b0;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wen   = bus.cpu_wen & bus.cpu_req;
    bus.cpu_stall = 1'b0;
    state_nx      = state;
    if (state == FETCH && (!bus.cpu_req || starve == S_W'(STARVE_LIMIT))) begin
      fetch_go      = 1'b1;
      bus.mem_addr  = base + ADDR_W'(k);
      bus.mem_wen   = 1'b0;
      bus.cpu_stall = bus.cpu_req;
    end
    if (row_start) begin
      state_nx = blank ? DONE : FETCH;
    end else begin
      case (state)
        FETCH:   if (fetch_go && k == K_W'(COLS - 1)) state_nx = DRAIN;
        DRAIN:   if (issued) state_nx = DONE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base    <= '0;
      k       <= '0;
      slot    <= '0;
      starve  <= '0;
      issued  <= 1'b0;
      overrun <= 1'b0;
    end else if (row_start) begin
      // A pending capture from the abandoned fetch is dropped here.
      base    <= ADDR_W'(32'(row_idx) * COLS);
      k       <= '0;
      starve  <= '0;
      issued  <= 1'b0;
      if (state == FETCH || state == DRAIN) overrun <= 1'b1;
    end else begin
      issued <= fetch_go;
      if (fetch_go) begin
        slot   <= k;
        k      <= k + 1'b1;
        starve <= '0;
      end else if (state == FETCH && bus.cpu_req) begin
        starve <= starve + 1'b1;
      end
    end
  end

  row_line_buffer #(
    .COLS  (COLS),
    .IDX_W (K_W)
  ) u_line_buffer (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (issued & ~row_start),
    .wr_idx  (slot),
    .wr_data (bus.mem_rdata),
    .swap    (row_start & (state == DONE)),
    .clear   (row_start & blank),
    .rd_idx  (col_idx),
    .rd_data (pix_color)
  );

endmodule

// File: tb/tb_board_row_fetcher.sv
// Directed bench for board_row_fetcher with a synchronous-read RAM model.
module tb_board_row_fetcher;
  import board_row_fetcher_pkg::*;

  logic       clock;
  logic       reset;
  logic       row_start;
  logic [4:0] row_idx;
  logic [3:0] col_idx;
  cell_t      pix_color;
  logic       row_ready;
  logic       overrun;

  int n_vec;
  int n_err;

  logic [2:0] ram [256];
  int row2_exp [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};

  board_row_fetcher_if #(.ADDR_W(12)) bus ();

  board_row_fetcher #(
    .COLS         (10),
    .ROWS         (20),
    .STARVE_LIMIT (8),
    .ADDR_W       (12)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .row_start (row_start),
    .row_idx   (row_idx),
    .bus       (bus.slave),
    .col_idx   (col_idx),
    .pix_color (pix_color),
    .row_ready (row_ready),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  always @(posedge clock) bus.mem_rdata <= ram[bus.mem_addr[7:0]];

  // Board contents outside row 2 follow a simple scatter so rows differ.
  function automatic logic [2:0] ramval(input int a);
    if (a >= 20 && a <= 29) return 3'(row2_exp[a-20]);
    return 3'((a * 5 + 3) % 8);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pix(input int c, input logic [2:0] exp);
    col_idx = 4'(c);
    #1;
    chk($sformatf("pix_col%0d", c), 32'(pix_color), 32'(exp));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    row_start = 1'b0;
    row_idx = '0;
    col_idx = '0;
    bus.cpu_req = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wen = 1'b0;
    for (int a = 0; a < 256; a++) ram[a] = ramval(a);
    repeat (3) tick();

    chk("rst_row_ready", 32'(row_ready), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_stall", 32'(bus.cpu_stall), 0);
    chk("rst_mem_wen", 32'(bus.mem_wen), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_pix", 32'(pix_color), 0);
    reset = 1'b1;
    tick();

    // CPU store while idle
    bus.cpu_req = 1'b1; bus.cpu_addr = 12'd45; bus.cpu_wen = 1'b1;
    #1;
    chk("sw_mem_addr", 32'(bus.mem_addr), 45);
    chk("sw_mem_wen", 32'(bus.mem_wen), 1);
    chk("sw_stall", 32'(bus.cpu_stall), 0);
    bus.cpu_req = 1'b0;
    #1;
    chk("noreq_mem_wen", 32'(bus.mem_wen), 0);
    bus.cpu_wen = 1'b0; bus.cpu_addr = '0;
    tick();

    // Uncontended fetch of row 2
    row_start = 1'b1; row_idx = 5'd2;
    tick();
    row_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("r2_addr%0d", k), 32'(bus.mem_addr), 32'(20 + k));
      chk("r2_mem_wen", 32'(bus.mem_wen), 0);
      chk("r2_not_ready", 32'(row_ready), 0);
      tick();
    end
    chk("r2_drain_not_ready", 32'(row_ready), 0);
    tick();
    chk("r2_ready_at_11", 32'(row_ready), 1);
    chk_pix(0, 3'd0);

    // Blank row: swaps in row 2, shadow zero-filled, done next cycle
    row_start = 1'b1; row_idx = 5'd25;
    tick();
    row_start = 1'b0;
    chk("blank_ready", 32'(row_ready), 1);
    chk("blank_no_addr", 32'(bus.mem_addr), 0);
    for (int c = 0; c < 10; c++) chk_pix(c, 3'(row2_exp[c]));
    chk_pix(10, 3'd0);
    chk_pix(15, 3'd0);
    row_start = 1'b1; row_idx = 5'd25;
    tick();
    row_start = 1'b0;
    chk("blank2_ready", 32'(row_ready), 1);
    for (int c = 0; c < 10; c++) chk_pix(c, 3'd0);

    // Continuous CPU traffic: one fetch slot every 9th cycle
    bus.cpu_req = 1'b1; bus.cpu_addr = 12'd100;
    row_start = 1'b1; row_idx = 5'd3;
    #1;
    chk("done_stall", 32'(bus.cpu_stall), 0);
    tick();
    row_start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      for (int j = 0; j < 8; j++) begin
        chk("starve_cpu_stall", 32'(bus.cpu_stall), 0);
        chk("starve_cpu_addr", 32'(bus.mem_addr), 100);
        tick();
      end
      chk($sformatf("starve_fetch_stall%0d", n), 32'(bus.cpu_stall), 1);
      chk($sformatf("starve_fetch_addr%0d", n), 32'(bus.mem_addr), 32'(30 + n));
      chk("starve_fetch_wen", 32'(bus.mem_wen), 0);
      tick();
    end
    chk("starve_drain_not_ready", 32'(row_ready), 0);
    tick();
    chk("starve_ready", 32'(row_ready), 1);
    bus.cpu_req = 1'b0; bus.cpu_addr = '0;

    // Restart mid-fetch: overrun, active buffer keeps row 3
    row_start = 1'b1; row_idx = 5'd4;
    tick();
    row_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("r4_addr%0d", k), 32'(bus.mem_addr), 32'(40 + k));
      tick();
    end
    chk("pre_overrun", 32'(overrun), 0);
    row_start = 1'b1; row_idx = 5'd6;
    tick();
    row_start = 1'b0;
    chk("overrun_set", 32'(overrun), 1);
    for (int c = 0; c < 10; c++) chk_pix(c, ramval(30 + c));
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("r6_addr%0d", k), 32'(bus.mem_addr), 32'(60 + k));
      tick();
    end
    chk("r6_drain_not_ready", 32'(row_ready), 0);
    tick();
    chk("r6_ready", 32'(row_ready), 1);
    chk("overrun_sticky", 32'(overrun), 1);

    // Reset during DRAIN
    row_start = 1'b1; row_idx = 5'd7;
    tick();
    row_start = 1'b0;
    repeat (10) tick();
    chk("r7_in_drain", 32'(row_ready), 0);
    chk_pix(3, ramval(63));
    reset = 1'b0;
    #1;
    chk("arst_row_ready", 32'(row_ready), 0);
    chk("arst_overrun", 32'(overrun), 0);
    chk("arst_stall", 32'(bus.cpu_stall), 0);
    chk("arst_mem_wen", 32'(bus.mem_wen), 0);
    chk("arst_mem_addr", 32'(bus.mem_addr), 0);
    chk_pix(3, 3'd0);
    tick();
    reset = 1'b1;
    tick();

    row_start = 1'b1; row_idx = 5'd1;
    tick();
    row_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("r1_addr%0d", k), 32'(bus.mem_addr), 32'(10 + k));
      tick();
    end
    tick();
    chk("r1_ready", 32'(row_ready), 1);
    row_start = 1'b1; row_idx = 5'd25;
    tick();
    row_start = 1'b0;
    for (int c = 0; c < 10; c++) chk_pix(c, ramval(10 + c));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
